// File: rtl/rv32i_data_mem.sv
// rv32i_data_mem: load/store responder with wait states, lane steering and a small MMIO window
module rv32i_data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] RAM_BASE    = 32'h8000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h0010_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h0000_6463
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [15:0] led_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        idle, commit, wr, ram_hit, mmio_hit, misalign, bad_f3, err;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, ram_off, old_word, bmask, merged, ld_sh, ld_val;
    logic [4:0]  sh;
    logic [3:0]  be;
    logic [AW-1:0] idx;

    // In IDLE the live request is decoded so a zero-wait access can commit on its accept edge.
    assign idle  = state_q == IDLE;
    assign wr    = idle ? req_write : wr_q;
    assign f3    = idle ? req_funct3 : f3_q;
    assign addr  = idle ? req_addr : addr_q;
    assign wdata = idle ? req_wdata : wdata_q;

    assign ram_off  = addr - RAM_BASE;
    assign ram_hit  = addr >= RAM_BASE && {1'b0, ram_off} < RAM_BYTES;
    assign idx      = ram_off[AW+1:2];
    assign mmio_hit = addr[31:4] == MMIO_BASE[31:4] && addr[3:2] != 2'b11;
    assign misalign = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign bad_f3   = wr ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    assign err      = bad_f3 || misalign || !(ram_hit || mmio_hit) || (mmio_hit && wr && addr[3:2] != 2'b10);

    assign old_word = ram_hit ? mem[idx] :
                      addr[3:2] == 2'b00 ? ID_VALUE :
                      addr[3:2] == 2'b01 ? {16'h0, sw_in} : {16'h0, led_q};
    assign sh       = {addr[1:0], 3'b000};
    assign be       = f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                      f3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    assign bmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign merged   = ((wdata << sh) & bmask) | (old_word & ~bmask);
    assign ld_sh    = old_word >> sh;
    assign ld_val   = f3[1:0] == 2'b00 ? {{24{~f3[2] & ld_sh[7]}}, ld_sh[7:0]} :
                      f3[1:0] == 2'b01 ? {{16{~f3[2] & ld_sh[15]}}, ld_sh[15:0]} : old_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (idle && req_valid) begin
            state_d = WAIT_STATES == 0 ? RESP : WAIT;
            cnt_d   = WAIT_INIT;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    assign commit = state_d == RESP && state_q != RESP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            led_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && req_valid) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                err_q   <= err;
                rdata_q <= (err || wr) ? 32'd0 : ld_val;
                if (!err && wr && !ram_hit) led_q <= merged[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && !err && wr && ram_hit) mem[idx] <= merged;
    end

    assign req_ready = idle;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_error = rsp_valid && err_q;
    assign led_out   = led_q;
endmodule

// File: tb/tb_rv32i_data_mem.sv
// tb_rv32i_data_mem: directed checks of rv32i_data_mem at WAIT_STATES=1 and a handshake run at 3
module tb_rv32i_data_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] sw_in;
    logic        r1, v1, e1, r3, v3, e3;
    logic [31:0] d1, d3;
    logic [15:0] l1, l3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32i_data_mem #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1),
        .rsp_rdata(d1), .rsp_error(e1), .sw_in(sw_in), .led_out(l1)
    );

    rv32i_data_mem #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r3), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v3),
        .rsp_rdata(d3), .rsp_error(e3), .sw_in(sw_in), .led_out(l3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        logic seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        while (!seen && n < 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
            seen = v1;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        chk({tag, " rdata"}, d1, exp_d);
        chk({tag, " error"}, {31'd0, e1}, {31'd0, exp_e});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic any;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; sw_in = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset ready", {31'd0, r1}, 32'd1);
        chk("reset rsp_valid", {31'd0, v1}, 32'd0);
        chk("reset rdata", d1, 32'd0);
        chk("reset error", {31'd0, e1}, 32'd0);
        chk("reset led", {16'd0, l1}, 32'd0);
        reset = 1'b0;

        access("sw deadbeef", 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        access("lw deadbeef", 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        access("sw zero", 1'b1, 3'b010, 32'h8000_0020, 32'd0, 32'd0, 1'b0);
        access("sb 80", 1'b1, 3'b000, 32'h8000_0023, 32'h0000_0080, 32'd0, 1'b0);
        access("lw after sb", 1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'h8000_0000, 1'b0);
        access("lb", 1'b0, 3'b000, 32'h8000_0023, 32'd0, 32'hFFFF_FF80, 1'b0);
        access("lbu", 1'b0, 3'b100, 32'h8000_0023, 32'd0, 32'h0000_0080, 1'b0);
        access("sh 1234", 1'b1, 3'b001, 32'h8000_0020, 32'h0000_1234, 32'd0, 1'b0);
        access("lw after sh", 1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'h8000_1234, 1'b0);
        access("lh", 1'b0, 3'b001, 32'h8000_0022, 32'd0, 32'hFFFF_8000, 1'b0);
        access("lhu", 1'b0, 3'b101, 32'h8000_0022, 32'd0, 32'h0000_8000, 1'b0);
        access("lw misaligned", 1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'd0, 1'b1);
        access("sh misaligned", 1'b1, 3'b001, 32'h8000_0021, 32'hFFFF_FFFF, 32'd0, 1'b1);
        access("lw after errors", 1'b0, 3'b010, 32'h8000_0020, 32'd0, 32'h8000_1234, 1'b0);
        access("load f3 011", 1'b0, 3'b011, 32'h8000_0010, 32'd0, 32'd0, 1'b1);
        access("store f3 100", 1'b1, 3'b100, 32'h8000_0010, 32'h0, 32'd0, 1'b1);
        access("lw untouched", 1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);

        access("sh led", 1'b1, 3'b001, 32'h0010_0008, 32'h0000_A5A5, 32'd0, 1'b0);
        chk("led after sh", {16'd0, l1}, 32'h0000_A5A5);
        access("lw id", 1'b0, 3'b010, 32'h0010_0000, 32'd0, 32'h0000_6463, 1'b0);
        sw_in = 16'h00FF;
        access("lw switches", 1'b0, 3'b010, 32'h0010_0004, 32'd0, 32'h0000_00FF, 1'b0);
        access("lw led", 1'b0, 3'b010, 32'h0010_0008, 32'd0, 32'h0000_A5A5, 1'b0);
        access("sw id", 1'b1, 3'b010, 32'h0010_0000, 32'h1, 32'd0, 1'b1);
        access("lw mmio hole", 1'b0, 3'b010, 32'h0010_000C, 32'd0, 32'd0, 1'b1);
        access("lw unmapped", 1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'd0, 1'b1);

        access("sw zero 40", 1'b1, 3'b010, 32'h8000_0040, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8000_0040; req_wdata = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("in wait ready", {31'd0, r1}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post reset ready", {31'd0, r1}, 32'd1);
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            any = any | v1;
            @(negedge clk);
        end
        chk("no rsp after reset", {31'd0, any}, 32'd0);
        chk("led cleared", {16'd0, l1}, 32'd0);
        access("lw discarded", 1'b0, 3'b010, 32'h8000_0040, 32'd0, 32'd0, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0010_0000;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("ws3 ready k%0d", k), {31'd0, r3}, {31'd0, k % 5 == 0});
            chk($sformatf("ws3 valid k%0d", k), {31'd0, v3}, {31'd0, k % 5 == 4});
            if (k % 5 == 4) chk($sformatf("ws3 rdata k%0d", k), d3, 32'h0000_6463);
            pulses += int'(v3);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("ws3 pulses", 32'(pulses), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
